// File: rtl/m_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : m_trap_sequencer
// Purpose  : Multi-cycle controller for machine-mode trap entry, MRET/SRET
//            return and WFI sleep. All traps are taken into M-mode.
//            There is no delegation.
// Ports    :
//   clk, rst_n               clock, asynchronous active-low reset
//   commit_*                 instruction at the commit point (pc, validity)
//   exc_req/exc_code/tval    exception raised by the committing instruction
//   sys_ops                  0 none, 1 SRET, 2 WFI, 3 MRET, 4 SFENCE_VMA
//   irq_pending/irq_code     pending-and-enabled interrupt summary
//   mstatus_*, mtvec, mepc,  CSR state needed to enter/leave traps
//   sepc
//   priv_mode                current privilege level
//   flush/stall              pipeline kill / fetch-decode freeze
//   redirect_valid/_pc       one-cycle PC redirect
//   trap_we/epc/cause/tval   CSR trap-write strobe and values
//   mret_done/sret_done      mstatus stack pop strobes
// Revision : 1.0 - initial release
// ============================================================================
module m_trap_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter logic [1:0]  RESET_PRIV = 2'b11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            exc_req,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [2:0]      sys_ops,
  input  logic            irq_pending,
  input  logic [3:0]      irq_code,
  input  logic            mstatus_mie,
  input  logic [1:0]      mstatus_mpp,
  input  logic            mstatus_spp,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  output logic [1:0]      priv_mode,
  output logic            flush,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_we,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_tval,
  output logic            mret_done,
  output logic            sret_done
);

  localparam logic [1:0]      PRIV_U     = 2'b00;
  localparam logic [1:0]      PRIV_M     = 2'b11;
  localparam logic [2:0]      SYS_SRET   = 3'd1;
  localparam logic [2:0]      SYS_WFI    = 3'd2;
  localparam logic [2:0]      SYS_MRET   = 3'd3;
  localparam logic [2:0]      SYS_SFENCE = 3'd4;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  typedef enum logic [2:0] {IDLE, SAVE, JUMP, RET, WFI_WAIT} state_t;

  state_t          state_q, state_d;

  // Trap context latched at detection and replayed in SAVE/JUMP
  logic [XLEN-1:0] epc_q, tval_q, ret_pc_q, last_pc_q;
  logic            cause_int_q;
  logic [3:0]      cause_code_q;
  logic [1:0]      ret_priv_q;
  logic            ret_mret_q;

  logic            load_trap, load_ret, load_wfi;
  logic [XLEN-1:0] epc_d, tval_d, ret_pc_d;
  logic            int_d, ret_mret_d;
  logic [3:0]      code_d;
  logic [1:0]      ret_priv_d;

  logic            irq_take;
  logic [XLEN-1:0] vec_base, vec_off;

  // Interrupts are always enabled below M-mode, gated by MIE in M-mode
  assign irq_take = irq_pending && (mstatus_mie || (priv_mode != PRIV_M));
  assign vec_base = {mtvec[XLEN-1:2], 2'b00};
  assign vec_off  = ((mtvec[1:0] == 2'b01) && cause_int_q) ?
                    {{(XLEN-6){1'b0}}, cause_code_q, 2'b00} : '0;

  assign trap_epc   = epc_q;
  assign trap_tval  = tval_q;
  assign trap_cause = {cause_int_q, {(XLEN-5){1'b0}}, cause_code_q};

  always_comb begin
    state_d        = state_q;
    flush          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    trap_we        = 1'b0;
    mret_done      = 1'b0;
    sret_done      = 1'b0;
    load_trap      = 1'b0;
    epc_d          = commit_pc;
    int_d          = 1'b0;
    code_d         = exc_code;
    tval_d         = exc_tval;
    load_ret       = 1'b0;
    ret_mret_d     = 1'b1;
    ret_pc_d       = mepc;
    ret_priv_d     = mstatus_mpp;
    load_wfi       = 1'b0;
    // Strobes are held low while reset is asserted, whatever the inputs do
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (commit_valid && exc_req) begin
            load_trap = 1'b1;
            flush     = 1'b1;
            state_d   = SAVE;
          end else if (irq_take) begin
            load_trap = 1'b1;
            flush     = 1'b1;
            epc_d     = commit_valid ? commit_pc : last_pc_q;
            int_d     = 1'b1;
            code_d    = irq_code;
            tval_d    = '0;
            state_d   = SAVE;
          end else if (commit_valid && ((sys_ops == SYS_MRET) || (sys_ops == SYS_SRET))) begin
            flush = 1'b1;
            if (((sys_ops == SYS_MRET) && (priv_mode != PRIV_M)) ||
                ((sys_ops == SYS_SRET) && (priv_mode == PRIV_U))) begin
              // Insufficient privilege: illegal-instruction trap
              load_trap = 1'b1;
              code_d    = 4'd2;
              tval_d    = '0;
              state_d   = SAVE;
            end else begin
              load_ret = 1'b1;
              state_d  = RET;
              if (sys_ops == SYS_SRET) begin
                ret_mret_d = 1'b0;
                ret_pc_d   = sepc;
                ret_priv_d = {1'b0, mstatus_spp};
              end else if (mstatus_mpp == 2'b10) begin
                ret_priv_d = PRIV_U;  // reserved encoding falls back to U
              end
            end
          end else if (commit_valid && (sys_ops == SYS_WFI)) begin
            stall    = 1'b1;
            load_wfi = 1'b1;
            state_d  = WFI_WAIT;
          end else if (commit_valid && (sys_ops == SYS_SFENCE)) begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = commit_pc + PC_STEP;
          end
        end
        WFI_WAIT: begin
          if (!irq_pending) begin
            stall = 1'b1;
          end else if (irq_take) begin
            flush     = 1'b1;
            load_trap = 1'b1;
            epc_d     = epc_q;  // already holds WFI pc + 4
            int_d     = 1'b1;
            code_d    = irq_code;
            tval_d    = '0;
            state_d   = SAVE;
          end else begin
            state_d = IDLE;     // wake without trap, resume at pc + 4
          end
        end
        SAVE: begin
          trap_we = 1'b1;
          stall   = 1'b1;
          state_d = JUMP;
        end
        JUMP: begin
          redirect_valid = 1'b1;
          redirect_pc    = vec_base + vec_off;
          state_d        = IDLE;
        end
        RET: begin
          redirect_valid = 1'b1;
          redirect_pc    = ret_pc_q;
          mret_done      = ret_mret_q;
          sret_done      = !ret_mret_q;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      priv_mode    <= RESET_PRIV;
      epc_q        <= '0;
      tval_q       <= '0;
      cause_int_q  <= 1'b0;
      cause_code_q <= '0;
      ret_pc_q     <= '0;
      ret_priv_q   <= '0;
      ret_mret_q   <= 1'b0;
      last_pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load_trap) begin
        epc_q        <= epc_d;
        cause_int_q  <= int_d;
        cause_code_q <= code_d;
        tval_q       <= tval_d;
      end else if (load_wfi) begin
        epc_q <= commit_pc + PC_STEP;
      end
      if (load_ret) begin
        ret_pc_q   <= ret_pc_d;
        ret_priv_q <= ret_priv_d;
        ret_mret_q <= ret_mret_d;
      end
      if ((state_q == IDLE) && commit_valid) begin
        last_pc_q <= commit_pc;
      end
      if (state_q == JUMP) begin
        priv_mode <= PRIV_M;
      end else if (state_q == RET) begin
        priv_mode <= ret_priv_q;
      end
    end
  end

endmodule
`default_nettype wire
